// File: rtl/alu_result_writeback.sv
`default_nettype none
// ============================================================================
// Module  : alu_result_writeback
// Brief   : Buffers 64-bit ALU results with their opcodes and sequences them
//           onto the 32-bit Z/LO/HI write-back path. Optional flags: ALU_WB_FLAGS_EN.
// Revision: 1.0 - initial release
// ============================================================================
module alu_result_writeback #(
    parameter int         DEPTH  = 2,
    parameter logic [4:0] MUL_OP = 5'b01111,
    parameter logic [4:0] DIV_OP = 5'b10000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [63:0] alu_c,
    input  logic [4:0]  alu_op,
    input  logic        alu_valid,
    output logic        alu_ready,
    output logic        wb_valid,
    input  logic        wb_ready,
    output logic [31:0] wb_data,
    output logic [1:0]  wb_sel,
    output logic        flag_z,
    output logic        flag_n
);

    localparam int               c_PTR_W    = $clog2(DEPTH);
    localparam logic [c_PTR_W-1:0] c_PTR_ONE  = c_PTR_W'(1);
    localparam logic [c_PTR_W:0]   c_CNT_ONE  = (c_PTR_W+1)'(1);
    localparam logic [c_PTR_W:0]   c_CNT_FULL = (c_PTR_W+1)'(DEPTH);

    localparam logic [1:0] c_IDLE    = 2'd0;
    localparam logic [1:0] c_BEAT_Z  = 2'd1;
    localparam logic [1:0] c_BEAT_LO = 2'd2;
    localparam logic [1:0] c_BEAT_HI = 2'd3;

    logic [68:0]        r_mem [DEPTH];
    logic [c_PTR_W-1:0] r_wr_ptr;
    logic [c_PTR_W-1:0] r_rd_ptr;
    logic [c_PTR_W:0]   r_count;
    logic [1:0]         r_state;
    logic [1:0]         w_state_nxt;
    logic [1:0]         w_after_pop;
    logic [c_PTR_W-1:0] w_rd_ptr_nxt;
    logic [63:0]        w_head_c;
    logic [4:0]         w_next_op;
    logic               w_push;
    logic               w_beat;
    logic               w_pop;

    function automatic logic [1:0] kind_of(input logic [4:0] op);
        return ((op == MUL_OP) || (op == DIV_OP)) ? c_BEAT_LO : c_BEAT_Z;
    endfunction

    assign alu_ready    = (r_count != c_CNT_FULL);
    assign w_push       = alu_valid && alu_ready;
    assign w_beat       = wb_valid && wb_ready;
    assign w_pop        = w_beat && ((r_state == c_BEAT_Z) || (r_state == c_BEAT_HI));
    assign w_rd_ptr_nxt = r_rd_ptr + c_PTR_ONE;
    assign w_head_c     = r_mem[r_rd_ptr][63:0];
    assign w_next_op    = r_mem[w_rd_ptr_nxt][68:64];

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= {alu_op, alu_c};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_state  <= c_IDLE;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + c_PTR_ONE;
            end
            if (w_pop) begin
                r_rd_ptr <= w_rd_ptr_nxt;
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + c_CNT_ONE;
            end else if (!w_push && w_pop) begin
                r_count <= r_count - c_CNT_ONE;
            end
            r_state <= w_state_nxt;
        end
    end

    // After a pop the successor is either already buffered or arriving this
    // very cycle, so it can be presented without a bubble.
    always_comb begin
        w_after_pop = c_IDLE;
        if (r_count > c_CNT_ONE) begin
            w_after_pop = kind_of(w_next_op);
        end else if (w_push) begin
            w_after_pop = kind_of(alu_op);
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        wb_valid    = 1'b0;
        wb_data     = 32'd0;
        wb_sel      = 2'b00;
        case (r_state)
            c_IDLE: begin
                if (w_push) begin
                    w_state_nxt = kind_of(alu_op);
                end
            end
            c_BEAT_Z: begin
                wb_valid = 1'b1;
                wb_data  = w_head_c[31:0];
                wb_sel   = 2'b00;
                if (w_beat) begin
                    w_state_nxt = w_after_pop;
                end
            end
            c_BEAT_LO: begin
                wb_valid = 1'b1;
                wb_data  = w_head_c[31:0];
                wb_sel   = 2'b01;
                if (w_beat) begin
                    w_state_nxt = c_BEAT_HI;
                end
            end
            default: begin
                wb_valid = 1'b1;
                wb_data  = w_head_c[63:32];
                wb_sel   = 2'b10;
                if (w_beat) begin
                    w_state_nxt = w_after_pop;
                end
            end
        endcase
    end

`ifdef ALU_WB_FLAGS_EN
    logic r_flag_z;
    logic r_flag_n;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_flag_z <= 1'b0;
            r_flag_n <= 1'b0;
        end else if (w_pop) begin
            if (r_state == c_BEAT_HI) begin
                r_flag_z <= (w_head_c == 64'd0);
                r_flag_n <= w_head_c[63];
            end else begin
                r_flag_z <= (w_head_c[31:0] == 32'd0);
                r_flag_n <= w_head_c[31];
            end
        end
    end

    assign flag_z = r_flag_z;
    assign flag_n = r_flag_n;
`else
    assign flag_z = 1'b0;
    assign flag_n = 1'b0;
`endif

endmodule
`default_nettype wire
